// File: rtl/rx_phase_slicer_pkg.sv
// Shared types and defaults for the oversampled phase-estimating slicer.
// The top, the energy bank and the bus interface all take their defaults from here.
package rx_phase_slicer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACQ   = 2'd1,
      ST_TRACK = 2'd2
   } state_t;

   localparam int DEF_NB_INPUT  = 8;
   localparam int DEF_NBF_INPUT = 7;
   localparam int DEF_N_PHASES  = 4;
   localparam int DEF_NB_SEL    = 2;
   localparam int DEF_NB_WIN    = 9;
   localparam int DEF_NB_ACC    = 16;

   // Largest representable magnitude; |most negative sample| is clipped to this.
   function automatic int sat_mag(input int nb_input);
      return (2 ** (nb_input - 1)) - 1;
   endfunction

endpackage

// File: rtl/rx_phase_slicer_if.sv
// Sample/control bus into the slicer and decision/status bus out of it.
interface rx_phase_slicer_if
   import rx_phase_slicer_pkg::*;
#(
   parameter int NB_INPUT = DEF_NB_INPUT,
   parameter int NB_SEL   = DEF_NB_SEL
);
   logic                       i_enable;
   logic                       i_valid;
   logic signed [NB_INPUT-1:0] i_sample;
   logic                       i_manual;
   logic [NB_SEL-1:0]          i_phase_sel;
   logic                       o_bit;
   logic                       o_bit_valid;
   logic [NB_SEL-1:0]          o_phase;
   logic                       o_locked;

   modport master (
      output i_enable, i_valid, i_sample, i_manual, i_phase_sel,
      input  o_bit, o_bit_valid, o_phase, o_locked
   );

   modport slave (
      input  i_enable, i_valid, i_sample, i_manual, i_phase_sel,
      output o_bit, o_bit_valid, o_phase, o_locked
   );
endinterface

// File: rtl/rx_phase_energy_acc.sv
// Per-phase |sample| energy accumulators with a combinational argmax that
// already includes the sample being accepted this cycle.
module rx_phase_energy_acc
   import rx_phase_slicer_pkg::*;
#(
   parameter int NB_INPUT = DEF_NB_INPUT,
   parameter int N_PHASES = DEF_N_PHASES,
   parameter int NB_SEL   = DEF_NB_SEL,
   parameter int NB_ACC   = DEF_NB_ACC
) (
   input  logic                       clock,
   input  logic                       i_reset,
   input  logic                       i_accept,
   input  logic                       i_clear,
   input  logic [NB_SEL-1:0]          i_phase,
   input  logic signed [NB_INPUT-1:0] i_sample,
   output logic [NB_SEL-1:0]          o_best
);
   localparam int SAT = sat_mag(NB_INPUT);
   localparam logic signed [NB_INPUT-1:0] SMIN = {1'b1, {(NB_INPUT-1){1'b0}}};

   logic [NB_INPUT-1:0] neg;
   logic [NB_INPUT-2:0] mag;
   logic [NB_ACC-1:0]   acc     [N_PHASES];
   logic [NB_ACC-1:0]   acc_nxt [N_PHASES];
   logic [NB_ACC-1:0]   best_val;

   assign neg = -i_sample;

   always_comb begin
      if (i_sample == SMIN)
         mag = SAT[NB_INPUT-2:0];
      else if (i_sample[NB_INPUT-1])
         mag = neg[NB_INPUT-2:0];
      else
         mag = i_sample[NB_INPUT-2:0];
   end

   always_comb begin
      for (int i = 0; i < N_PHASES; i++)
         acc_nxt[i] = acc[i] + ((i_accept && (i_phase == NB_SEL'(i))) ? NB_ACC'(mag) : '0);
   end

   // Strict '>' keeps the lowest index on ties.
   always_comb begin
      o_best   = '0;
      best_val = acc_nxt[0];
      for (int i = 1; i < N_PHASES; i++) begin
         if (acc_nxt[i] > best_val) begin
            best_val = acc_nxt[i];
            o_best   = NB_SEL'(i);
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < N_PHASES; i++) begin
         if (i_reset || i_clear)
            acc[i] <= '0;
         else
            acc[i] <= acc_nxt[i];
      end
   end

endmodule

// File: rtl/rx_phase_slicer.sv
// Oversampled symbol slicer: estimates the max-energy decimation phase over a
// 2^NB_WIN symbol window and emits one hard decision per symbol.
module rx_phase_slicer
   import rx_phase_slicer_pkg::*;
#(
   parameter int NB_INPUT  = DEF_NB_INPUT,
   parameter int NBF_INPUT = DEF_NBF_INPUT,
   parameter int N_PHASES  = DEF_N_PHASES,
   parameter int NB_SEL    = DEF_NB_SEL,
   parameter int NB_WIN    = DEF_NB_WIN,
   parameter int NB_ACC    = DEF_NB_ACC
) (
   input  logic             clock,
   input  logic             i_reset,
   rx_phase_slicer_if.slave bus
);
   // Sign bit sits above the fractional and remaining integer bits.
   localparam int NBI_INPUT = NB_INPUT - NBF_INPUT;
   localparam int MSB       = NBI_INPUT + NBF_INPUT - 1;
   localparam logic [NB_SEL-1:0] LAST_PHASE = NB_SEL'(N_PHASES - 1);
   localparam logic [NB_WIN-1:0] LAST_SYM   = '1;

   state_t            state;
   logic [NB_SEL-1:0] phase_cnt;
   logic [NB_WIN-1:0] sym_cnt;
   logic [NB_SEL-1:0] phase_r;
   logic [NB_SEL-1:0] best_phase;
   logic [NB_SEL-1:0] dec_phase;
   logic              bit_r, bit_valid_r, locked_r;
   logic              accept, phase_wrap, win_end, slice;

   assign accept     = bus.i_enable & bus.i_valid;
   assign phase_wrap = (phase_cnt == LAST_PHASE);
   assign win_end    = accept & phase_wrap & (sym_cnt == LAST_SYM);
   assign dec_phase  = bus.i_manual ? bus.i_phase_sel : phase_r;
   assign slice      = accept & (phase_cnt == dec_phase) &
                       (bus.i_manual | (state == ST_TRACK));

   rx_phase_energy_acc #(
      .NB_INPUT (NB_INPUT),
      .N_PHASES (N_PHASES),
      .NB_SEL   (NB_SEL),
      .NB_ACC   (NB_ACC)
   ) u_acc (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_accept (accept),
      .i_clear  (win_end),
      .i_phase  (phase_cnt),
      .i_sample (bus.i_sample),
      .o_best   (best_phase)
   );

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state       <= ST_IDLE;
         phase_cnt   <= '0;
         sym_cnt     <= '0;
         phase_r     <= '0;
         bit_r       <= 1'b0;
         bit_valid_r <= 1'b0;
         locked_r    <= 1'b0;
      end else if (bus.i_enable) begin
         bit_valid_r <= slice;
         if (slice)
            bit_r <= bus.i_sample[MSB];
         if (accept) begin
            phase_cnt <= phase_wrap ? '0 : phase_cnt + 1'b1;
            if (phase_wrap)
               sym_cnt <= sym_cnt + 1'b1;
         end
         if (win_end)
            phase_r <= best_phase;
         case (state)
            ST_IDLE: begin
               state <= win_end ? ST_TRACK : ST_ACQ;
               if (win_end) locked_r <= 1'b1;
            end
            ST_ACQ: begin
               if (win_end) begin
                  state    <= ST_TRACK;
                  locked_r <= 1'b1;
               end
            end
            ST_TRACK: locked_r <= 1'b1;
            default: begin
               state    <= ST_IDLE;
               locked_r <= 1'b0;
            end
         endcase
      end else begin
         bit_valid_r <= 1'b0;
      end
   end

   assign bus.o_bit       = bit_r;
   assign bus.o_bit_valid = bit_valid_r;
   assign bus.o_phase     = phase_r;
   assign bus.o_locked    = locked_r;

endmodule

// File: tb/tb_rx_phase_slicer.sv
// Bench for rx_phase_slicer: vector table, directed window scenarios and a
// randomized run against an integer reference model.
module tb_rx_phase_slicer;

   logic clock = 1'b0;
   logic i_reset;
   always #5 clock = ~clock;

   rx_phase_slicer_if bus ();

   rx_phase_slicer dut (
      .clock   (clock),
      .i_reset (i_reset),
      .bus     (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: counts accepted samples since reset; phase and window
   // position follow from plain division of that count.
   int m_cnt;
   int m_e[4];
   int m_est;
   bit m_lock, m_bit, m_vld;
   bit use_model = 1'b1;
   int strobes;

   typedef struct {
      bit rst, en, val;
      int smp;
      bit man;
      int sel;
      bit e_vld, e_bit, e_lock;
      int e_ph;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input integer act, input integer exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, en, val, input int smp, input bit man, input int sel);
      int ph, a, dec;
      if (rst) begin
         m_cnt = 0; m_e = '{default: 0}; m_est = 0;
         m_lock = 0; m_bit = 0; m_vld = 0;
      end else if (!en || !val) begin
         m_vld = 0;
      end else begin
         ph  = m_cnt % 4;
         a   = (smp < 0) ? -smp : smp;
         if (a > 127) a = 127;
         dec = man ? sel : m_est;
         m_e[ph] += a;
         m_vld = (ph == dec) && (man || m_lock);
         if (m_vld) m_bit = (smp < 0);
         if (m_cnt % 2048 == 2047) begin
            m_est = 0;
            for (int i = 1; i < 4; i++) if (m_e[i] > m_e[m_est]) m_est = i;
            m_lock = 1;
            m_e = '{default: 0};
         end
         m_cnt++;
      end
   endtask

   task automatic apply(input bit rst, en, val, input int smp, input bit man, input int sel);
      i_reset         = rst;
      bus.i_enable    = en;
      bus.i_valid     = val;
      bus.i_sample    = smp[7:0];
      bus.i_manual    = man;
      bus.i_phase_sel = sel[1:0];
      @(posedge clock);
      #1;
      model_step(rst, en, val, smp, man, sel);
      if (bus.o_bit_valid === 1'b1) strobes++;
      if (use_model) begin
         chk("bit_valid", bus.o_bit_valid, m_vld);
         chk("bit",       bus.o_bit,       m_bit);
         chk("phase",     bus.o_phase,     m_est);
         chk("locked",    bus.o_locked,    m_lock);
      end
   endtask

   task automatic auto_run(input int n, input int p0, p1, p2, p3);
      int pat[4];
      pat = '{p0, p1, p2, p3};
      for (int k = 0; k < n; k++) apply(0, 1, 1, pat[m_cnt % 4], 0, 0);
   endtask

   initial begin
      // en/val/sample/manual/sel -> expected valid/bit/locked/phase
      tbl[0]  = '{1, 0, 0,    0, 0, 0,  0, 0, 0, 0};
      tbl[1]  = '{0, 1, 1,    0, 1, 1,  0, 0, 0, 0};
      tbl[2]  = '{0, 1, 1,  -50, 1, 1,  1, 1, 0, 0};
      tbl[3]  = '{0, 1, 1,    0, 1, 1,  0, 1, 0, 0};
      tbl[4]  = '{0, 1, 1,    0, 1, 1,  0, 1, 0, 0};
      tbl[5]  = '{0, 1, 1,    0, 1, 1,  0, 1, 0, 0};
      tbl[6]  = '{0, 1, 0,  -50, 1, 1,  0, 1, 0, 0};
      tbl[7]  = '{0, 0, 1,  -50, 1, 1,  0, 1, 0, 0};
      tbl[8]  = '{0, 1, 1,   50, 1, 1,  1, 0, 0, 0};
      tbl[9]  = '{0, 1, 1,  -50, 0, 1,  0, 0, 0, 0};
      tbl[10] = '{0, 1, 1,   -1, 1, 3,  1, 1, 0, 0};
      tbl[11] = '{1, 1, 1, -128, 1, 0,  0, 0, 0, 0};
      tbl[12] = '{0, 0, 1, -128, 1, 0,  0, 0, 0, 0};
      tbl[13] = '{0, 1, 1, -128, 1, 0,  1, 1, 0, 0};

      apply(1, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0);

      use_model = 1'b0;
      foreach (tbl[i]) begin
         apply(tbl[i].rst, tbl[i].en, tbl[i].val, tbl[i].smp, tbl[i].man, tbl[i].sel);
         chk($sformatf("tbl%0d_vld", i),  bus.o_bit_valid, tbl[i].e_vld);
         chk($sformatf("tbl%0d_bit", i),  bus.o_bit,       tbl[i].e_bit);
         chk($sformatf("tbl%0d_lock", i), bus.o_locked,    tbl[i].e_lock);
         chk($sformatf("tbl%0d_ph", i),   bus.o_phase,     tbl[i].e_ph);
      end
      use_model = 1'b1;

      // Auto acquisition: phase 2 carries the most energy.
      apply(1, 0, 0, 0, 0, 0);
      auto_run(2047, 10, 60, 120, 60);
      chk("lock_before_2048", bus.o_locked, 0);
      auto_run(1, 10, 60, 120, 60);
      chk("lock_after_2048",  bus.o_locked, 1);
      chk("phase_after_2048", bus.o_phase,  2);
      strobes = 0;
      auto_run(8, 10, 60, 120, 60);
      chk("strobes_in_8", strobes, 2);
      chk("bit_track", bus.o_bit, 0);

      // Equal magnitude on every phase: tie goes to phase 0.
      apply(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2048; k++) apply(0, 1, 1, ($urandom_range(0, 1) != 0) ? 64 : -64, 0, 0);
      chk("tie_phase", bus.o_phase, 0);
      chk("tie_lock",  bus.o_locked, 1);

      // Full-scale negative window: saturated magnitude, no wrap.
      apply(1, 0, 0, 0, 0, 0);
      auto_run(2048, -128, -128, -128, -128);
      chk("sat_phase", bus.o_phase, 0);
      chk("sat_lock",  bus.o_locked, 1);

      // Enable pause mid-window while tracking; estimate moves to phase 1.
      auto_run(700, 5, 90, 30, 20);
      strobes = 0;
      for (int k = 0; k < 10; k++) apply(0, 0, 1, -128, 0, 0);
      chk("pause_strobes", strobes, 0);
      auto_run(2048 - 700, 5, 90, 30, 20);
      chk("pause_phase", bus.o_phase, 1);

      // Reset part way through a window discards the partial accumulation.
      for (int k = 0; k < 1000; k++) apply(0, 1, 1, $urandom_range(0, 255) - 128, 0, 0);
      apply(1, 1, 1, -128, 1, 0);
      chk("rst_vld",  bus.o_bit_valid, 0);
      chk("rst_bit",  bus.o_bit,       0);
      chk("rst_ph",   bus.o_phase,     0);
      chk("rst_lock", bus.o_locked,    0);
      auto_run(2047, 3, 7, 1, 9);
      chk("rst_lock_2047", bus.o_locked, 0);
      auto_run(1, 3, 7, 1, 9);
      chk("rst_lock_2048", bus.o_locked, 1);
      chk("rst_phase_2048", bus.o_phase, 3);

      // Randomized run.
      begin
         bit man;
         int sel;
         man = 0;
         sel = 0;
         apply(1, 0, 0, 0, 0, 0);
         for (int k = 0; k < 8000; k++) begin
            if ($urandom_range(0, 49) == 0) man = ~man;
            if ($urandom_range(0, 99) == 0) sel = $urandom_range(0, 3);
            apply($urandom_range(0, 3999) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 255) - 128, man, sel);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_phase_slicer.md
RX_PHASE_SLICER -- requirements
Module: rx_phase_slicer

Interface
REQ-001 SHALL have parameter NB_INPUT, default 8, total bits of input sample.
REQ-002 SHALL have parameter NBF_INPUT, default 7, fractional bits of input sample.
REQ-003 SHALL have parameter N_PHASES, default 4, samples per symbol.
REQ-004 SHALL have parameter NB_SEL, default 2, phase index width.
REQ-005 SHALL have parameter NB_WIN, default 9, symbol-window counter width (window = 2^NB_WIN symbols).
REQ-006 SHALL have parameter NB_ACC, default 16, energy accumulator width (>= NB_INPUT-1+NB_WIN).
REQ-007 SHALL have port clock  input  1  system clock; all logic on rising edge.
REQ-008 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port i_enable  input  1  block enable; low freezes all state.
REQ-010 SHALL have port i_valid  input  1  i_sample qualifier, one oversampled sample per asserted cycle.
REQ-011 SHALL have port i_sample  input  NB_INPUT  signed oversampled filter output.
REQ-012 SHALL have port i_manual  input  1  1 = use i_phase_sel, 0 = use estimated phase.
REQ-013 SHALL have port i_phase_sel  input  NB_SEL  manual decimation phase.
REQ-014 SHALL have port o_bit  output  1  sliced symbol decision.
REQ-015 SHALL have port o_bit_valid  output  1  one-cycle strobe qualifying o_bit.
REQ-016 SHALL have port o_phase  output  NB_SEL  currently estimated best phase.
REQ-017 SHALL have port o_locked  output  1  at least one estimation window completed.

Function
REQ-018 Phase counter SHALL advance on each i_valid&i_enable, wrapping N_PHASES-1 -> 0.
REQ-019 Symbol counter SHALL advance when phase counter wraps; wraps 2^NB_WIN-1 -> 0.
REQ-020 Each accepted sample SHALL add |i_sample| to acc[phase counter]; |-2^(NB_INPUT-1)| saturates to 2^(NB_INPUT-1)-1.
REQ-021 Window end = accepted sample with phase = N_PHASES-1 and symbol count = 2^NB_WIN-1.
REQ-022 At window end SHALL register o_phase = index of max acc (that last sample included); ties resolve to lowest index.
REQ-023 At window end all accumulators SHALL clear next cycle; that cycle's next sample starts the new window.
REQ-024 FSM states: IDLE, ACQ, TRACK; IDLE->ACQ when i_enable=1; ACQ->TRACK at first window end; TRACK re-estimates every window.
REQ-025 o_locked SHALL be 1 exactly in TRACK; o_phase updates only at window ends.
REQ-026 Decimation phase SHALL be i_phase_sel when i_manual=1, else o_phase; i_manual change takes effect on next sample.
REQ-027 When accepted sample phase = decimation phase and (i_manual=1 or state=TRACK): o_bit <= i_sample MSB, o_bit_valid <= 1, latency 1 cycle.
REQ-028 Otherwise o_bit_valid SHALL be 0; o_bit holds last value.
REQ-029 i_enable=0 SHALL hold counters, accumulators, state, o_bit, o_phase; o_bit_valid forced 0; resume without loss.
REQ-030 i_valid=0 cycles SHALL not advance counters or accumulators.

Reset
REQ-031 i_reset SHALL dominate i_enable: counters=0, acc=0, state=IDLE, o_bit=0, o_bit_valid=0, o_phase=0, o_locked=0.
REQ-032 Reset mid-window SHALL discard partial accumulation; next estimate needs a full window.

Structure
REQ-033 Shared package SHALL hold FSM state encoding, default N_PHASES/NB_SEL/NB_WIN/NB_ACC and saturation constant.
REQ-034 Accumulator bank plus argmax SHALL be sub-module rx_phase_energy_acc; FSM, counters, slicer in top.

Verification
REQ-035 Auto mode, samples repeating {+10,+60,+120,+60} per symbol, 512 symbols -> o_locked=1, o_phase=2 after 2048th sample; then o_bit_valid every 4th sample, o_bit=0.
REQ-036 Manual, i_phase_sel=1, samples {0,-50,0,0} repeated -> first strobe 1 cycle after 2nd sample, o_bit=1, o_locked stays 0 before 2048 samples.
REQ-037 Equal |x|=64 on all phases for full window -> o_phase=0 (tie rule).
REQ-038 All samples -128 for full window -> each acc = 127*512 = 65024, no overflow, o_phase=0.
REQ-039 i_enable low 10 cycles mid-window, i_valid held high -> no strobes, counters frozen, o_phase at window end identical to uninterrupted run.
REQ-040 i_reset at sample 1000 of a window -> all outputs 0, state IDLE; lock asserts only 2048 accepted samples after release.
